// File: rtl/video_timing_pkg.sv
// Shared raster constants and coordinate type for the HDMI video timing path.
// Holds the CEA-861 720p60 and 640x480p60 sets plus a helper for axis totals.
package video_timing_pkg;

  localparam int COORD_W   = 12;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // 1280x720p60, 74.25 MHz pixel clock, 1650x750 total
  localparam int P720_H_ACTIVE = 1280;
  localparam int P720_H_FP     = 110;
  localparam int P720_H_SYNC   = 40;
  localparam int P720_H_BP     = 220;
  localparam int P720_V_ACTIVE = 720;
  localparam int P720_V_FP     = 5;
  localparam int P720_V_SYNC   = 5;
  localparam int P720_V_BP     = 20;
  localparam bit P720_HS_POL   = 1'b1;
  localparam bit P720_VS_POL   = 1'b1;

  // 640x480p60, 25.175 MHz pixel clock, 800x525 total, negative syncs
  localparam int P480_H_ACTIVE = 640;
  localparam int P480_H_FP     = 16;
  localparam int P480_H_SYNC   = 96;
  localparam int P480_H_BP     = 48;
  localparam int P480_V_ACTIVE = 480;
  localparam int P480_V_FP     = 10;
  localparam int P480_V_SYNC   = 2;
  localparam int P480_V_BP     = 33;
  localparam bit P480_HS_POL   = 1'b0;
  localparam bit P480_VS_POL   = 1'b0;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/timing_axis_cnt.sv
// One raster axis: counts 0..TOTAL-1 on step, flags the active region and
// drives the sync level (POL inside the sync window, ~POL elsewhere).
module timing_axis_cnt
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = P720_H_ACTIVE,
  parameter int FP     = P720_H_FP,
  parameter int SYNC   = P720_H_SYNC,
  parameter int BP     = P720_H_BP,
  parameter bit POL    = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  output coord_t cnt,
  output logic   wrap,
  output logic   active,
  output logic   sync_act
);

  localparam int     TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam int     SYNC_BEG = ACTIVE + FP;
  localparam int     SYNC_END = ACTIVE + FP + SYNC;

  if (TOTAL > COORD_MAX) begin : g_total_chk
    $error("timing_axis_cnt: axis total %0d exceeds 12-bit counter range", TOTAL);
  end

  coord_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Compare in 32 bits so a window ending exactly at 4096 does not alias to 0.
  assign cnt      = cnt_q;
  assign wrap     = step && (cnt_q == LAST);
  assign active   = int'(cnt_q) < ACTIVE;
  assign sync_act = ((int'(cnt_q) >= SYNC_BEG) && (int'(cnt_q) < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters plus a registered
// output stage that decodes syncs, data enable, coordinates and start pulses.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = P720_H_ACTIVE,
  parameter int H_FP     = P720_H_FP,
  parameter int H_SYNC   = P720_H_SYNC,
  parameter int H_BP     = P720_H_BP,
  parameter int V_ACTIVE = P720_V_ACTIVE,
  parameter int V_FP     = P720_V_FP,
  parameter int V_SYNC   = P720_V_SYNC,
  parameter int V_BP     = P720_V_BP,
  parameter bit HS_POL   = P720_HS_POL,
  parameter bit VS_POL   = P720_VS_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start
);

  coord_t h_cnt, v_cnt;
  logic   h_wrap, h_act, h_sync, v_act, v_sync;
  // Frame boundaries are decoded from the counts, so the vertical wrap is spare.
  logic   v_wrap_unused;

  timing_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .clk(clk), .rst(rst), .step(en),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync_act(h_sync)
  );

  timing_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .clk(clk), .rst(rst), .step(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap_unused), .active(v_act), .sync_act(v_sync)
  );

  logic   hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic   ls_q, ls_d, fs_q, fs_d;
  coord_t x_q, x_d, y_q, y_d;

  // With en low the pulses and de drop while syncs and coordinates freeze.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    x_d     = x_q;
    y_d     = y_q;
    de_d    = 1'b0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (en) begin
      hsync_d = h_sync;
      vsync_d = v_sync;
      de_d    = h_act && v_act;
      x_d     = de_d ? h_cnt : '0;
      y_d     = de_d ? v_cnt : '0;
      ls_d    = (h_cnt == '0);
      fs_d    = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three rasters (720p defaults, an 8x8 active-low
// raster and a 55x33 raster) checked every cycle against a raster model.
module tb_video_timing_gen;

  typedef struct {
    int ha, hfp, hs, hb, va, vfp, vs, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    bit hs, vs, de, ls, fs;
    int x, y;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;

  logic        hs_w[3], vs_w[3], de_w[3], ls_w[3], fs_w[3];
  logic [11:0] x_w[3], y_w[3];

  cfg_t cfg[3];
  out_t exp_o[3];
  int   k[3];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int a_ls_q[$], a_fs_q[$], a_defall_q[$], a_hsr_q[$], a_hsf_q[$];
  int b_fs_q[$];
  int c_fs_q[$], c_vsr_q[$], c_vsf_q[$], c_der_q[$];
  logic prev_de[3], prev_hs[3], prev_vs[3];

  always #5 clk = ~clk;

  video_timing_gen u_a (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hs_w[0]), .vsync(vs_w[0]), .de(de_w[0]), .x(x_w[0]), .y(y_w[0]),
    .line_start(ls_w[0]), .frame_start(fs_w[0])
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hs_w[1]), .vsync(vs_w[1]), .de(de_w[1]), .x(x_w[1]), .y(y_w[1]),
    .line_start(ls_w[1]), .frame_start(fs_w[1])
  );

  video_timing_gen #(
    .H_ACTIVE(40), .H_FP(5), .H_SYNC(4), .H_BP(6),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_c (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hs_w[2]), .vsync(vs_w[2]), .de(de_w[2]), .x(x_w[2]), .y(y_w[2]),
    .line_start(ls_w[2]), .frame_start(fs_w[2])
  );

  // Raster position is simply the number of enabled edges since reset,
  // folded into (h, v) with division; outputs follow from the window rules.
  function automatic out_t decode(input cfg_t c, input int kk);
    int ht, vt, pos, h, v;
    out_t o;
    ht   = c.ha + c.hfp + c.hs + c.hb;
    vt   = c.va + c.vfp + c.vs + c.vb;
    pos  = kk % (ht * vt);
    h    = pos % ht;
    v    = pos / ht;
    o.de = (h < c.ha) && (v < c.va);
    o.hs = ((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs)) ? c.hp : !c.hp;
    o.vs = ((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs)) ? c.vp : !c.vp;
    o.x  = o.de ? h : 0;
    o.y  = o.de ? v : 0;
    o.ls = (h == 0);
    o.fs = (pos == 0);
    return o;
  endfunction

  function automatic out_t reset_out(input cfg_t c);
    out_t o;
    o.hs = !c.hp;
    o.vs = !c.vp;
    o.de = 1'b0;
    o.ls = 1'b0;
    o.fs = 1'b0;
    o.x  = 0;
    o.y  = 0;
    return o;
  endfunction

  function automatic out_t paused(input out_t p);
    out_t o;
    o    = p;
    o.de = 1'b0;
    o.ls = 1'b0;
    o.fs = 1'b0;
    return o;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000000;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s[dut%0d]: got %0d want %0d (cycle %0d)", nm, idx, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        exp_o[i] <= reset_out(cfg[i]);
        k[i]     <= 0;
      end else if (en) begin
        exp_o[i] <= decode(cfg[i], k[i]);
        k[i]     <= k[i] + 1;
      end else begin
        exp_o[i] <= paused(exp_o[i]);
      end
    end
  end

  // Per-cycle compare against the model, plus event logs for the literal checks.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("hsync", i, hs_w[i], exp_o[i].hs);
      chk("vsync", i, vs_w[i], exp_o[i].vs);
      chk("de", i, de_w[i], exp_o[i].de);
      chk("x", i, x_w[i], exp_o[i].x);
      chk("y", i, y_w[i], exp_o[i].y);
      chk("line_start", i, ls_w[i], exp_o[i].ls);
      chk("frame_start", i, fs_w[i], exp_o[i].fs);
    end
    if (ls_w[0]) a_ls_q.push_back(cyc);
    if (fs_w[0]) a_fs_q.push_back(cyc);
    if (prev_de[0] && !de_w[0]) a_defall_q.push_back(cyc);
    if (!prev_hs[0] && hs_w[0]) a_hsr_q.push_back(cyc);
    if (prev_hs[0] && !hs_w[0]) a_hsf_q.push_back(cyc);
    if (fs_w[1]) b_fs_q.push_back(cyc);
    if (fs_w[2]) c_fs_q.push_back(cyc);
    if (!prev_vs[2] && vs_w[2]) c_vsr_q.push_back(cyc);
    if (prev_vs[2] && !vs_w[2]) c_vsf_q.push_back(cyc);
    if (!prev_de[2] && de_w[2]) c_der_q.push_back(cyc);
    for (int i = 0; i < 3; i++) begin
      prev_de[i] <= de_w[i];
      prev_hs[i] <= hs_w[i];
      prev_vs[i] <= vs_w[i];
    end
  end

  initial begin
    int rel, pidx, nde, fs0, fs1;
    bit found;

    cfg[0] = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
    cfg[1] = '{4, 1, 2, 1, 4, 1, 2, 1, 1'b0, 1'b0};
    cfg[2] = '{40, 5, 4, 6, 24, 2, 3, 4, 1'b1, 1'b1};
    rst = 1'b1;
    en  = 1'b1;

    repeat (10) @(posedge clk);
    #1;
    chk("rst_hsync", 0, hs_w[0], 0);
    chk("rst_vsync", 0, vs_w[0], 0);
    chk("rst_de", 0, de_w[0], 0);
    chk("rst_x", 0, x_w[0], 0);
    chk("rst_y", 0, y_w[0], 0);
    chk("rst_ls", 0, ls_w[0], 0);
    chk("rst_fs", 0, fs_w[0], 0);
    chk("rst_hsync_lowpol", 1, hs_w[1], 1);
    chk("rst_vsync_lowpol", 1, vs_w[1], 1);

    rst = 1'b0;
    rel = cyc + 1;
    repeat (3500) @(posedge clk);
    #1;

    // 720p line timing
    chk("fs_first_edge", 0, qget(a_fs_q, 0), rel);
    chk("ls_first_edge", 0, qget(a_ls_q, 0), rel);
    chk("de_fall_off", 0, qget(a_defall_q, 0) - qget(a_fs_q, 0), 1280);
    chk("hs_rise_off", 0, qget(a_hsr_q, 0) - qget(a_ls_q, 0), 1390);
    chk("hs_width", 0, qget(a_hsf_q, 0) - qget(a_hsr_q, 0), 40);
    chk("ls_period0", 0, qget(a_ls_q, 1) - qget(a_ls_q, 0), 1650);
    chk("ls_period1", 0, qget(a_ls_q, 2) - qget(a_ls_q, 1), 1650);

    // Small active-low raster wraps every 64 cycles with no gap
    chk("b_frame_period", 1, qget(b_fs_q, 1) - qget(b_fs_q, 0), 64);
    chk("b_frame_period2", 1, qget(b_fs_q, 2) - qget(b_fs_q, 1), 64);

    // 55x33 raster frame timing
    fs0 = qget(c_fs_q, 0);
    fs1 = qget(c_fs_q, 1);
    chk("c_frame_period", 2, fs1 - fs0, 1815);
    chk("c_vs_rise_off", 2, qget(c_vsr_q, 0) - fs0, 26 * 55);
    chk("c_vs_width", 2, qget(c_vsf_q, 0) - qget(c_vsr_q, 0), 3 * 55);
    nde = 0;
    foreach (c_der_q[i]) if (c_der_q[i] >= fs0 && c_der_q[i] < fs1) nde++;
    chk("c_de_lines", 2, nde, 24);

    // Pause for 100 edges while the 720p raster shows x=500
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      #1;
      found = de_w[0] && (x_w[0] == 12'd500);
    end
    chk("find_x500", 0, found, 1);
    pidx = c_fs_q.size();
    en = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("pause_de", 0, de_w[0], 0);
    chk("pause_x_hold", 0, x_w[0], 500);
    repeat (50) @(posedge clk);
    #1;
    chk("pause_x_hold_end", 0, x_w[0], 500);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_de", 0, de_w[0], 1);
    chk("resume_x", 0, x_w[0], 501);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge clk);
      #1;
      found = (c_fs_q.size() > pidx);
    end
    chk("c_fs_after_pause", 2, found, 1);
    chk("c_frame_stretched", 2, qget(c_fs_q, pidx) - qget(c_fs_q, pidx - 1), 1915);

    // Asynchronous reset mid-frame
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge clk);
      #1;
      found = de_w[2] && (y_w[2] == 12'd20);
    end
    chk("find_c_line20", 2, found, 1);
    rst = 1'b1;
    #1;
    chk("arst_hsync", 0, hs_w[0], 0);
    chk("arst_vsync", 0, vs_w[0], 0);
    chk("arst_de", 0, de_w[0], 0);
    chk("arst_x", 0, x_w[0], 0);
    chk("arst_y", 0, y_w[0], 0);
    chk("arst_de_c", 2, de_w[2], 0);
    chk("arst_y_c", 2, y_w[2], 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_fs", 0, fs_w[0], 1);
    chk("post_rst_ls", 0, ls_w[0], 1);
    chk("post_rst_de", 0, de_w[0], 1);
    chk("post_rst_x", 0, x_w[0], 0);
    chk("post_rst_y", 0, y_w[0], 0);
    chk("post_rst_fs_c", 2, fs_w[2], 1);
    repeat (200) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
